// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: datapath width, instruction-memory sizing
// and the special NOP/HALT encodings seen by the fetch stage.
package mips_pkg;
  localparam int NB         = 32;
  localparam int ADDR_W_DEF = 10;

  localparam logic [NB-1:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [NB-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/instruction_memory.sv
// Simple dual-port instruction RAM: one debug write port, one synchronous read
// port whose output register doubles as the IF/ID instruction register.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int NB     = mips_pkg::NB,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NB-1:0]     wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [NB-1:0]     rd_data
);
  logic [NB-1:0] mem [2**ADDR_W];

  // Array carries no reset so the debug-loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rd_data <= NOP_INSTR;
    else if (rd_clr) rd_data <= NOP_INSTR;
    else if (rd_en)  rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC+4 adder, IF/ID register (instruction held in the RAM read
// register), PC write-enable and sticky HALT detection.
module instruction_fetch_stage
  import mips_pkg::*;
#(
  parameter int NB     = mips_pkg::NB,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic [NB-1:0]     i_pc,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [NB-1:0]     i_wr_data,
  output logic [NB-1:0]     o_pc_plus4,
  output logic              o_pc_enable,
  output logic [NB-1:0]     o_if_id_instr,
  output logic [NB-1:0]     o_if_id_pc4,
  output logic              o_if_id_valid,
  output logic              o_halt
);
  fetch_state_t state_q, state_d;
  logic         halt_hit;
  logic         advance;
  logic         clr;
  logic         pc_unused;

  assign pc_unused   = ^{i_pc[1:0], i_pc[NB-1:ADDR_W+2]};
  assign o_pc_plus4  = i_pc + NB'(4);

  // HALT is recognised as soon as it sits valid in IF/ID, so o_halt rises on
  // the same edge that loads it; the state register keeps it sticky.
  assign halt_hit    = o_if_id_valid && (o_if_id_instr == HALT_INSTR);
  assign o_halt      = (state_q == HALTED) || halt_hit;
  assign o_pc_enable = i_enable & ~i_stall & ~o_halt;

  assign advance = i_enable & ~i_flush & ~i_stall & ~o_halt;
  assign clr     = i_enable & (i_flush | (~i_stall & o_halt));

  instruction_memory #(.NB(NB), .ADDR_W(ADDR_W)) u_imem (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .wr_en   (i_wr_en & ~i_enable),
    .wr_addr (i_wr_addr),
    .wr_data (i_wr_data),
    .rd_en   (advance),
    .rd_clr  (clr),
    .rd_addr (i_pc[ADDR_W+1:2]),
    .rd_data (o_if_id_instr)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_hit) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_if_id_pc4   <= '0;
      o_if_id_valid <= 1'b0;
    end else if (i_enable) begin
      if (i_flush) begin
        o_if_id_pc4   <= '0;
        o_if_id_valid <= 1'b0;
      end else if (!i_stall) begin
        if (o_halt) begin
          o_if_id_valid <= 1'b0;
        end else begin
          o_if_id_pc4   <= o_pc_plus4;
          o_if_id_valid <= 1'b1;
        end
      end
    end
  end
endmodule
